// File: rtl/core_seq_pkg.sv
// Shared types and helpers for the instruction fetch/issue sequencer.
package core_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   localparam logic [3:0] OPCODE_HALT     = 4'hF;
   localparam int         INSTR_MAX_WIDTH = 64;
   localparam int         PERF_WIDTH      = 32;

   // Opcode is the top nibble of an instruction of the given width.
   function automatic logic [3:0] get_opcode(input logic [INSTR_MAX_WIDTH-1:0] instr,
                                             input int width);
      return 4'(instr >> (width - 4));
   endfunction

endpackage

// File: rtl/core_seq_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module core_seq_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   // Count up on inc until the counter reaches its maximum value.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/core_sequencer.sv
// Instruction fetch/issue sequencer: reads a 1-cycle-latency ROM, issues one
// instruction per cycle, handles stall replay and branch redirect, and drains
// the datapath after HALT before raising stop_o.
// Optional performance counters are built when CORE_SEQ_PERF_EN is defined.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = 8,
   parameter int                    INSTR_WIDTH     = 16,
   parameter int                    PIPELINE_LENGTH = 2,
   parameter logic [ADDR_WIDTH-1:0] START_PC        = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic [INSTR_WIDTH-1:0] imem_data_i,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic                   instr_valid_o,
   output logic [ADDR_WIDTH-1:0]  issue_pc_o,
   output logic                   busy_o,
   output logic                   stop_o,
   output logic [31:0]            perf_issued_o,
   output logic [31:0]            perf_bubbles_o
);

   localparam int CNT_W = $clog2(PIPELINE_LENGTH + 1);

   seq_state_e             state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
   logic [ADDR_WIDTH-1:0]  f_pc_reg, f_pc_next;
   logic                   f_valid_reg, f_valid_next;
   logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
   logic                   valid_reg, valid_next;
   logic [ADDR_WIDTH-1:0]  issue_pc_reg, issue_pc_next;
   logic                   stop_reg, stop_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   is_halt;

   assign is_halt = (get_opcode(INSTR_MAX_WIDTH'(imem_data_i), INSTR_WIDTH) == OPCODE_HALT);

   // State register; reset discards any in-flight fetch and never raises stop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         pc_reg       <= START_PC;
         f_pc_reg     <= START_PC;
         f_valid_reg  <= 1'b0;
         instr_reg    <= '0;
         valid_reg    <= 1'b0;
         issue_pc_reg <= '0;
         stop_reg     <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         f_pc_reg     <= f_pc_next;
         f_valid_reg  <= f_valid_next;
         instr_reg    <= instr_next;
         valid_reg    <= valid_next;
         issue_pc_reg <= issue_pc_next;
         stop_reg     <= stop_next;
         cnt_reg      <= cnt_next;
      end
   end

   // Next-state logic: redirect beats stall beats normal fetch/issue in RUN.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      f_pc_next     = f_pc_reg;
      f_valid_next  = f_valid_reg;
      instr_next    = instr_reg;
      valid_next    = 1'b0;
      issue_pc_next = issue_pc_reg;
      stop_next     = stop_reg;
      cnt_next      = cnt_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_next   = ST_RUN;
               pc_next      = START_PC;
               f_pc_next    = START_PC;
               f_valid_next = 1'b0;
               stop_next    = 1'b0;
            end
         end
         ST_RUN: begin
            if (redirect_i) begin
               pc_next      = redirect_pc_i;
               f_valid_next = 1'b0;
            end else if (stall_i) begin
               // Refetch the pending address so nothing is skipped.
               pc_next      = f_pc_reg;
               f_valid_next = 1'b0;
            end else begin
               pc_next      = pc_reg + ADDR_WIDTH'(1);
               f_pc_next    = pc_reg;
               f_valid_next = 1'b1;
               if (f_valid_reg) begin
                  if (is_halt) begin
                     state_next = ST_DRAIN;
                     cnt_next   = CNT_W'(PIPELINE_LENGTH - 1);
                  end else begin
                     instr_next    = imem_data_i;
                     issue_pc_next = f_pc_reg;
                     valid_next    = 1'b1;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_reg == '0) begin
               state_next = ST_DONE;
               stop_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign imem_addr_o   = pc_reg;
   assign instr_o       = instr_reg;
   assign instr_valid_o = valid_reg;
   assign issue_pc_o    = issue_pc_reg;
   assign stop_o        = stop_reg;
   assign busy_o        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

`ifdef CORE_SEQ_PERF_EN
   // Counter 0 tracks issued instructions, counter 1 tracks RUN-cycle bubbles.
   logic                  start_accept;
   logic [1:0]            perf_inc;
   logic [PERF_WIDTH-1:0] perf_count [2];

   assign start_accept = start_i && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign perf_inc[0]  = valid_next;
   assign perf_inc[1]  = (state_reg == ST_RUN) && !valid_next;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_perf
         core_seq_sat_counter #(.WIDTH(PERF_WIDTH)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (start_accept),
            .inc   (perf_inc[gi]),
            .count (perf_count[gi])
         );
      end
   endgenerate

   assign perf_issued_o  = perf_count[0];
   assign perf_bubbles_o = perf_count[1];
`else
   assign perf_issued_o  = '0;
   assign perf_bubbles_o = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-cycle vector tables for the main scenarios,
// a scoreboard of expected issue PCs checked on every valid issue, and a
// second instance exercising START_PC wraparound. Honours CORE_SEQ_PERF_EN.
module tb_core_sequencer;

   typedef struct {
      logic       stall;
      logic       redirect;
      logic [7:0] rpc;
      logic       v;
      logic [7:0] pc;
      logic       busy;
      logic       stop;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, start, stall, redirect;
   logic [7:0]  redirect_pc;
   logic [7:0]  imem_addr, issue_pc;
   logic [15:0] imem_data, instr;
   logic        instr_valid, busy, stop;
   logic [31:0] perf_issued, perf_bubbles;

   logic        start2;
   logic [7:0]  imem_addr2, issue_pc2;
   logic [15:0] imem_data2, instr2;
   logic        instr_valid2, busy2, stop2;
   logic [31:0] perf_issued2, perf_bubbles2;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];
   vec_t        tbl [64];
   int          n_vec = 0;
   int          base_a, base_b, base_c, base_d;

   always #5 clk = ~clk;

   core_sequencer dut (
      .clk(clk), .reset(reset), .start_i(start),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .instr_o(instr), .instr_valid_o(instr_valid), .issue_pc_o(issue_pc),
      .busy_o(busy), .stop_o(stop),
      .perf_issued_o(perf_issued), .perf_bubbles_o(perf_bubbles)
   );

   core_sequencer #(.START_PC(8'hFE)) dut_fe (
      .clk(clk), .reset(reset), .start_i(start2),
      .imem_addr_o(imem_addr2), .imem_data_i(imem_data2),
      .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(8'h00),
      .instr_o(instr2), .instr_valid_o(instr_valid2), .issue_pc_o(issue_pc2),
      .busy_o(busy2), .stop_o(stop2),
      .perf_issued_o(perf_issued2), .perf_bubbles_o(perf_bubbles2)
   );

   // ROM image: ADD everywhere, SUB at 1, HALT at 2, 9 and 0x44.
   function automatic logic [15:0] rom_word(input logic [7:0] a);
      case (a)
         8'h01:               return {4'h2, 4'h0, a};
         8'h02, 8'h09, 8'h44: return {4'hF, 4'h0, a};
         default:             return {4'h1, 4'h0, a};
      endcase
   endfunction

   always @(posedge clk) begin
      imem_data  <= rom_word(imem_addr);
      imem_data2 <= rom_word(imem_addr2);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every issue must match the oldest expected PC and its ROM word.
   always @(negedge clk) begin
      if (!reset && instr_valid) begin
         $display("issue pc=%02h instr=%04h", issue_pc, instr);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_issue actual=%02h required=none", issue_pc);
         end else begin
            logic [7:0] pe;
            pe = exp_q.pop_front();
            check("sb_pc", 32'(issue_pc), 32'(pe));
            check("sb_instr", 32'(instr), 32'(rom_word(pe)));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic s, input logic r, input logic [7:0] rpc,
                      input logic v, input logic [7:0] pc, input logic b, input logic st);
      tbl[n_vec] = '{stall: s, redirect: r, rpc: rpc, v: v, pc: pc, busy: b, stop: st};
      n_vec++;
   endtask

   task automatic run_table(input int first, input int count);
      for (int i = 0; i < count; i++) begin
         vec_t t;
         t           = tbl[first + i];
         stall       = t.stall;
         redirect    = t.redirect;
         redirect_pc = t.rpc;
         cyc();
         stall    = 1'b0;
         redirect = 1'b0;
         check($sformatf("row%0d_valid", first + i), 32'(instr_valid), 32'(t.v));
         if (t.v) check($sformatf("row%0d_pc", first + i), 32'(issue_pc), 32'(t.pc));
         check($sformatf("row%0d_busy", first + i), 32'(busy), 32'(t.busy));
         check($sformatf("row%0d_stop", first + i), 32'(stop), 32'(t.stop));
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_valid", 32'(instr_valid), 32'd0);
      check("start_stop", 32'(stop), 32'd0);
   endtask

   task automatic check_perf(input string name, input int iss, input int bub);
`ifdef CORE_SEQ_PERF_EN
      check({name, "_issued"}, perf_issued, 32'(iss));
      check({name, "_bubbles"}, perf_bubbles, 32'(bub));
`else
      check({name, "_issued"}, perf_issued, 32'(iss & 0));
      check({name, "_bubbles"}, perf_bubbles, 32'(bub & 0));
`endif
   endtask

   task automatic check_sb_empty(input string name);
      check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Scenario A: ROM {ADD, SUB, HALT} from start.
      base_a = n_vec;
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h01, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 0, 1);
      add(0, 0, 8'h00, 0, 8'h00, 0, 1);
      // Scenario B: redirect to 4, then one-cycle stall while pc 5 pending.
      base_b = n_vec;
      add(0, 1, 8'h04, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h04, 1, 0);
      add(1, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h05, 1, 0);
      add(0, 0, 8'h00, 1, 8'h06, 1, 0);
      add(0, 0, 8'h00, 1, 8'h07, 1, 0);
      add(0, 0, 8'h00, 1, 8'h08, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 0, 1);
      // Scenario C: scenario A with a stall while pc 0 pending.
      base_c = n_vec;
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(1, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h01, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 0, 1);
      // Scenario D: redirect to 0x40 while HALT is pending; stall/redirect in DRAIN.
      base_d = n_vec;
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h01, 1, 0);
      add(0, 1, 8'h40, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 1, 8'h40, 1, 0);
      add(0, 0, 8'h00, 1, 8'h41, 1, 0);
      add(0, 0, 8'h00, 1, 8'h42, 1, 0);
      add(0, 0, 8'h00, 1, 8'h43, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 1, 0);
      add(1, 1, 8'h10, 0, 8'h00, 1, 0);
      add(0, 0, 8'h00, 0, 8'h00, 0, 1);

      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      repeat (3) cyc();
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_issue_pc", 32'(issue_pc), 32'd0);
      check("rst_stop", 32'(stop), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check_perf("rst", 0, 0);
      reset = 1'b0;
      repeat (2) cyc();
      check("idle_busy", 32'(busy), 32'd0);

      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      do_start();
      run_table(base_a, 7);
      check_sb_empty("a");
      check_perf("a", 2, 2);

      exp_q = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      do_start();
      run_table(base_b, 12);
      check_sb_empty("b");
      check_perf("b", 5, 5);

      exp_q = '{8'h00, 8'h01};
      do_start();
      run_table(base_c, 8);
      check_sb_empty("c");
      check_perf("c", 2, 4);
      cyc();
      check_perf("c_hold", 2, 4);

      exp_q = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h42, 8'h43};
      do_start();
      run_table(base_d, 12);
      check_sb_empty("d");
      check_perf("d", 6, 4);

      // Scenario E: reset while draining after HALT.
      exp_q = '{8'h00, 8'h01};
      do_start();
      run_table(base_a, 4);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rd_valid", 32'(instr_valid), 32'd0);
      check("rd_instr", 32'(instr), 32'd0);
      check("rd_issue_pc", 32'(issue_pc), 32'd0);
      check("rd_stop", 32'(stop), 32'd0);
      check("rd_busy", 32'(busy), 32'd0);
      check("rd_addr", 32'(imem_addr), 32'd0);
      check_perf("rd", 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check($sformatf("rd_idle%0d_stop", i), 32'(stop), 32'd0);
         check($sformatf("rd_idle%0d_busy", i), 32'(busy), 32'd0);
      end
      check_sb_empty("e");
      exp_q = '{8'h00, 8'h01};
      do_start();
      run_table(base_a, 7);
      check_sb_empty("e_rerun");

      // Scenario F: START_PC=0xFE wraps FE, FF, 00, 01 then HALT at 02.
      begin
         logic [7:0] seq [4];
         seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
         start2 = 1'b1;
         cyc();
         start2 = 1'b0;
         cyc();
         check("fe_first_valid", 32'(instr_valid2), 32'd0);
         for (int j = 0; j < 4; j++) begin
            cyc();
            $display("issue2 pc=%02h instr=%04h valid=%0d", issue_pc2, instr2, instr_valid2);
            check($sformatf("fe%0d_valid", j), 32'(instr_valid2), 32'd1);
            check($sformatf("fe%0d_pc", j), 32'(issue_pc2), 32'(seq[j]));
            check($sformatf("fe%0d_instr", j), 32'(instr2), 32'(rom_word(seq[j])));
         end
         cyc();
         check("fe_halt_valid", 32'(instr_valid2), 32'd0);
         repeat (2) cyc();
         check("fe_stop", 32'(stop2), 32'd1);
         check("fe_busy", 32'(busy2), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
